// File: rtl/console_arbiter_pkg.sv
// Shared definitions for the console arbiter: newline default, FSM encoding,
// and the owner-index width helper.
package console_pkg;

    localparam logic [7:0] NEWLINE_BYTE = 8'h0A;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    // Index width for n requesters, never narrower than one bit.
    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/console_arbiter_if.sv
// Requester-side handshake plus console output bundle for console_arbiter.
// The arbiter uses the slave modport, the requesters/pins use the master modport.
interface console_arbiter_if #(
    parameter int NUM_REQ = 4
) ();
    import console_pkg::*;

    localparam int IDW = idw(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           out_byte;
    logic                 out_byte_en;
    logic [IDW-1:0]       owner;
    logic                 owner_valid;

    modport master (
        output req_valid, req_data,
        input  req_ready, out_byte, out_byte_en, owner, owner_valid
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, out_byte, out_byte_en, owner, owner_valid
    );

endinterface

// File: rtl/console_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or after
// ptr (wrapping), reported as an index plus an any-request flag.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] grant,
    output logic           any
);

    int idx;

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any && req[idx]) begin
                grant = IDW'(idx);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/console_arbiter.sv
// Line-locked round-robin arbiter that merges NUM_REQ byte streams onto one
// console output, with optional inter-byte pacing and an idle-owner timeout.
module console_arbiter
    import console_pkg::*;
#(
    parameter int         NUM_REQ      = 4,
    parameter int         GAP_CYCLES   = 0,
    parameter int         HOLD_TIMEOUT = 256,
    parameter logic [7:0] NEWLINE      = NEWLINE_BYTE
) (
    input logic               clk,
    input logic               resetn,
    console_arbiter_if.slave  bus
);

    localparam int IDW = idw(NUM_REQ);
    localparam int GW  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int TW  = $clog2(HOLD_TIMEOUT + 1);

    localparam logic [GW-1:0]  GAP_LOAD = GW'(GAP_CYCLES);
    localparam logic [TW-1:0]  TO_LAST  = TW'(HOLD_TIMEOUT - 1);
    localparam logic [IDW-1:0] LAST_ID  = IDW'(NUM_REQ - 1);

    state_e         state_q, state_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic [TW-1:0]  timeout_q, timeout_d;
    logic [7:0]     out_byte_q, out_byte_d;
    logic           out_en_q, out_en_d;

    logic [NUM_REQ-1:0] ready;
    logic [IDW-1:0]     pick_id;
    logic               pick_any;
    logic [7:0]         owner_data;
    logic               owner_valid_in;
    logic               fire;
    logic [IDW-1:0]     next_ptr;

    rr_pick #(.N(NUM_REQ), .IDW(IDW)) u_pick (
        .req   (bus.req_valid),
        .ptr   (ptr_q),
        .grant (pick_id),
        .any   (pick_any)
    );

    // Ready depends on registered state only, so valid never loops back into ready.
    always_comb begin
        ready = '0;
        if (state_q == ST_LOCKED && gap_q == '0) begin
            ready[owner_q] = 1'b1;
        end
    end

    assign owner_data     = bus.req_data[{owner_q, 3'b000} +: 8];
    assign owner_valid_in = bus.req_valid[owner_q];
    assign fire           = ready[owner_q] & owner_valid_in;
    assign next_ptr       = (owner_q == LAST_ID) ? '0 : owner_q + IDW'(1);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        timeout_d  = timeout_q;
        out_byte_d = out_byte_q;
        out_en_d   = 1'b0;
        gap_d      = (gap_q != '0) ? gap_q - GW'(1) : gap_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    owner_d   = pick_id;
                    timeout_d = '0;
                    state_d   = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (fire) begin
                    out_byte_d = owner_data;
                    out_en_d   = 1'b1;
                    gap_d      = GAP_LOAD;
                    timeout_d  = '0;
                    if (owner_data == NEWLINE) begin
                        state_d = ST_IDLE;
                        ptr_d   = next_ptr;
                    end
                end else if (!owner_valid_in) begin
                    // The owner went quiet for too long: give the console away.
                    if (timeout_q == TO_LAST) begin
                        timeout_d = '0;
                        state_d   = ST_IDLE;
                        ptr_d     = next_ptr;
                    end else begin
                        timeout_d = timeout_q + TW'(1);
                    end
                end else begin
                    timeout_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments; reset is synchronous, so it is sampled only on clk.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            ptr_q      <= '0;
            gap_q      <= '0;
            timeout_q  <= '0;
            out_byte_q <= '0;
            out_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            gap_q      <= gap_d;
            timeout_q  <= timeout_d;
            out_byte_q <= out_byte_d;
            out_en_q   <= out_en_d;
        end
    end

    assign bus.req_ready   = ready;
    assign bus.out_byte    = out_byte_q;
    assign bus.out_byte_en = out_en_q;
    assign bus.owner       = owner_q;
    assign bus.owner_valid = (state_q == ST_LOCKED);

endmodule
